// File: rtl/cache_flush_sequencer.sv
// Flush walker: visits every (set, way), writes back valid dirty lines over a
// req/ack handshake, clears their dirty bits and pulses FlushDone at the end.
//
// state | meaning
// IDLE  | waiting for FlushStart; cache owns the set-address mux
// READ  | FlushAdr presented, tag/dirty array read in flight
// CHECK | examine valid & dirty of way WayCnt in the held read data
// WB    | WritebackReq held until WritebackAck
// CLEAR | one-cycle ClearDirty for the line just written back
// DONE  | one-cycle FlushDone, then back to IDLE
module cache_flush_sequencer #(
    parameter int NUMWAYS  = 4,
    parameter int NUMLINES = 128,
    parameter int SETLEN   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FlushStart,
    input  logic [NUMWAYS-1:0] ValidWay,
    input  logic [NUMWAYS-1:0] DirtyWay,
    input  logic               WritebackAck,
    output logic [SETLEN-1:0]  FlushAdr,
    output logic [NUMWAYS-1:0] FlushWay,
    output logic               SelFlush,
    output logic               WritebackReq,
    output logic               ClearDirty,
    output logic               FlushDone
);

    localparam int WAYLEN = $clog2(NUMWAYS);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WB,
        CLEAR,
        DONE
    } stateType;

    stateType            state, nextState;
    logic [SETLEN-1:0]   setCnt, nextSet;
    logic [WAYLEN-1:0]   wayCnt, nextWay;
    logic                lastWay, lastSet, lineHit;

    assign lastWay = (wayCnt == WAYLEN'(NUMWAYS - 1));
    assign lastSet = (setCnt == SETLEN'(NUMLINES - 1));
    assign lineHit = ValidWay[wayCnt] & DirtyWay[wayCnt];

    always_comb begin
        nextState = state;
        nextSet   = setCnt;
        nextWay   = wayCnt;
        case (state)
            IDLE: begin
                if (FlushStart) begin
                    nextState = READ;
                    nextSet   = '0;
                    nextWay   = '0;
                end
            end
            READ:  nextState = CHECK;
            CHECK: begin
                if (lineHit) begin
                    nextState = WB;
                end else if (!lastWay) begin
                    nextState = CHECK;
                    nextWay   = wayCnt + 1'b1;
                end else if (!lastSet) begin
                    nextState = READ;
                    nextWay   = '0;
                    nextSet   = setCnt + 1'b1;
                end else begin
                    nextState = DONE;
                end
            end
            WB: begin
                if (WritebackAck) nextState = CLEAR;
            end
            CLEAR: begin
                // read data for this set is still held, so stay in CHECK for the next way
                if (!lastWay) begin
                    nextState = CHECK;
                    nextWay   = wayCnt + 1'b1;
                end else if (!lastSet) begin
                    nextState = READ;
                    nextWay   = '0;
                    nextSet   = setCnt + 1'b1;
                end else begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
                nextSet   = '0;
                nextWay   = '0;
            end
            default: begin
                nextState = IDLE;
                nextSet   = '0;
                nextWay   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            setCnt       <= '0;
            wayCnt       <= '0;
            SelFlush     <= 1'b0;
            WritebackReq <= 1'b0;
            ClearDirty   <= 1'b0;
            FlushDone    <= 1'b0;
        end else begin
            state        <= nextState;
            setCnt       <= nextSet;
            wayCnt       <= nextWay;
            SelFlush     <= (nextState != IDLE);
            WritebackReq <= (nextState == WB);
            ClearDirty   <= (nextState == CLEAR);
            FlushDone    <= (nextState == DONE);
        end
    end

    assign FlushAdr = setCnt;
    // gated so the way select reads as zero for as long as reset is held
    assign FlushWay = reset ? '0 : (NUMWAYS'(1) << wayCnt);

endmodule

// File: tb/tb_cache_flush_sequencer.sv
// Randomized bench for cache_flush_sequencer: a cache array model plus an
// expected per-cycle trace built by walking sets/ways with plain loops.
module tb_cache_flush_sequencer;
    localparam int W = 4;
    localparam int L = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         FlushStart;
    logic [W-1:0] ValidWay;
    logic [W-1:0] DirtyWay;
    logic         WritebackAck;
    logic [S-1:0] FlushAdr;
    logic [W-1:0] FlushWay;
    logic         SelFlush;
    logic         WritebackReq;
    logic         ClearDirty;
    logic         FlushDone;

    cache_flush_sequencer #(.NUMWAYS(W), .NUMLINES(L), .SETLEN(S)) dut (
        .clk(clk), .reset(reset), .FlushStart(FlushStart),
        .ValidWay(ValidWay), .DirtyWay(DirtyWay), .WritebackAck(WritebackAck),
        .FlushAdr(FlushAdr), .FlushWay(FlushWay), .SelFlush(SelFlush),
        .WritebackReq(WritebackReq), .ClearDirty(ClearDirty), .FlushDone(FlushDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit sel; int adr; int way; bit req; bit clr; bit done; bit ack; bit pos;
    } ent_t;

    ent_t         expQ[$];
    int           latTab[$];
    bit           valid[L][W];
    bit           dirty[L][W];
    logic [S-1:0] lastAdr = '0;
    int           compared = 0;
    int           mismatched = 0;

    task automatic chk(input string nm, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic ent_t mk(bit sel, int adr, int way, bit req, bit clr, bit done, bit ack, bit pos);
        ent_t e;
        e.sel = sel; e.adr = adr; e.way = way; e.req = req;
        e.clr = clr; e.done = done; e.ack = ack; e.pos = pos;
        return e;
    endfunction

    // Expected trace: each set costs a read cycle plus one check per way;
    // each valid dirty line adds (latency+1) request cycles and a clear.
    task automatic buildExpect(output int nWb);
        int lat;
        expQ.delete();
        nWb = 0;
        for (int s = 0; s < L; s++) begin
            expQ.push_back(mk(1, s, 1, 0, 0, 0, 0, 1));
            for (int w = 0; w < W; w++) begin
                expQ.push_back(mk(1, s, 1 << w, 0, 0, 0, 0, 1));
                if (valid[s][w] && dirty[s][w]) begin
                    lat = (nWb < latTab.size()) ? latTab[nWb] : 0;
                    for (int k = 0; k <= lat; k++)
                        expQ.push_back(mk(1, s, 1 << w, 1, 0, 0, k == lat, 1));
                    expQ.push_back(mk(1, s, 1 << w, 0, 1, 0, 0, 1));
                    nWb++;
                end
            end
        end
        expQ.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
    endtask

    // One clock: registered array read of last cycle's address, dirty clear.
    task automatic step();
        @(negedge clk);
        for (int w = 0; w < W; w++) begin
            ValidWay[w] = valid[lastAdr][w];
            DirtyWay[w] = dirty[lastAdr][w];
        end
        lastAdr = FlushAdr;
        if (ClearDirty)
            for (int w = 0; w < W; w++)
                if (FlushWay[w]) dirty[FlushAdr][w] = 1'b0;
    endtask

    task automatic fill(input int mode);
        for (int s = 0; s < L; s++)
            for (int w = 0; w < W; w++) begin
                case (mode)
                    0: begin valid[s][w] = 1; dirty[s][w] = 0; end
                    1: begin valid[s][w] = 1; dirty[s][w] = 1; end
                    2: begin valid[s][w] = 0; dirty[s][w] = 1; end
                    default: begin valid[s][w] = $urandom_range(0, 1); dirty[s][w] = $urandom_range(0, 1); end
                endcase
            end
    endtask

    task automatic runFlush(input string nm, input bit spam, input bit noise, input int pinDone, input int pinClr);
        int nWb, doneAt, doneCnt, clrCnt, resid;
        ent_t e;
        buildExpect(nWb);
        step();
        FlushStart = 1'b1;
        WritebackAck = 1'b0;
        doneAt = -1; doneCnt = 0; clrCnt = 0;
        for (int i = 0; i < expQ.size(); i++) begin
            step();
            e = expQ[i];
            FlushStart = spam;
            chk({nm, ".SelFlush"}, int'(SelFlush), int'(e.sel));
            chk({nm, ".WritebackReq"}, int'(WritebackReq), int'(e.req));
            chk({nm, ".ClearDirty"}, int'(ClearDirty), int'(e.clr));
            chk({nm, ".FlushDone"}, int'(FlushDone), int'(e.done));
            if (e.pos) begin
                chk({nm, ".FlushAdr"}, int'(FlushAdr), e.adr);
                chk({nm, ".FlushWay"}, int'(FlushWay), e.way);
            end
            if (FlushDone) begin doneAt = i + 1; doneCnt++; end
            if (ClearDirty) clrCnt++;
            WritebackAck = e.ack | (noise && !e.req && ($urandom_range(0, 1) == 1));
        end
        step();
        FlushStart = 1'b0;
        WritebackAck = 1'b0;
        chk({nm, ".idleSel"}, int'(SelFlush), 0);
        chk({nm, ".idleDone"}, int'(FlushDone), 0);
        step();
        chk({nm, ".stayIdle"}, int'(SelFlush), 0);
        chk({nm, ".doneCycle"}, doneAt, (pinDone > 0) ? pinDone : expQ.size());
        chk({nm, ".doneCount"}, doneCnt, 1);
        chk({nm, ".clearCount"}, clrCnt, (pinClr >= 0) ? pinClr : nWb);
        resid = 0;
        for (int s = 0; s < L; s++)
            for (int w = 0; w < W; w++)
                if (valid[s][w] && dirty[s][w]) resid++;
        chk({nm, ".residualDirty"}, resid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset = 1'b1; FlushStart = 1'b0; WritebackAck = 1'b0;
        ValidWay = '0; DirtyWay = '0;
        fill(0);
        #12;
        chk("reset.SelFlush", int'(SelFlush), 0);
        chk("reset.FlushWay", int'(FlushWay), 0);
        chk("reset.FlushDone", int'(FlushDone), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("postReset.FlushWay", int'(FlushWay), 1);
        chk("postReset.FlushAdr", int'(FlushAdr), 0);

        latTab.delete();
        fill(0);
        runFlush("clean", 0, 0, 21, 0);

        fill(0);
        dirty[2][3] = 1;
        latTab.delete(); latTab.push_back(3);
        runFlush("single", 0, 0, 26, 1);

        fill(1);
        latTab.delete();
        for (int i = 0; i < 16; i++) latTab.push_back(0);
        runFlush("allDirty", 0, 0, 53, 16);

        fill(2);
        latTab.delete();
        runFlush("dirtyNotValid", 0, 1, 21, 0);

        // reset while a writeback request is outstanding
        fill(0);
        dirty[1][2] = 1;
        step();
        FlushStart = 1'b1;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            FlushStart = 1'b0;
            WritebackAck = 1'b0;
            if (WritebackReq) seen = 1;
        end
        chk("midWb.reqSeen", int'(seen), 1);
        reset = 1'b1;
        #1;
        chk("midWb.SelFlush", int'(SelFlush), 0);
        chk("midWb.WritebackReq", int'(WritebackReq), 0);
        chk("midWb.ClearDirty", int'(ClearDirty), 0);
        chk("midWb.FlushDone", int'(FlushDone), 0);
        chk("midWb.FlushWay", int'(FlushWay), 0);
        chk("midWb.FlushAdr", int'(FlushAdr), 0);
        step();
        step();
        chk("midWb.heldClear", int'(ClearDirty), 0);
        chk("midWb.heldDone", int'(FlushDone), 0);
        reset = 1'b0;
        #1;
        chk("midWb.releaseWay", int'(FlushWay), 1);
        latTab.delete(); latTab.push_back(2);
        runFlush("restart", 0, 0, 21 + 3 + 1, 1);

        for (int r = 0; r < 3; r++) begin
            fill(3);
            latTab.delete();
            for (int i = 0; i < 16; i++) latTab.push_back($urandom_range(0, 3));
            runFlush($sformatf("rand%0d", r), 0, 1, 0, -1);
        end

        fill(3);
        latTab.delete();
        for (int i = 0; i < 16; i++) latTab.push_back($urandom_range(0, 2));
        runFlush("spam", 1, 1, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/cache_flush_sequencer.md
Name: cache_flush_sequencer

Overview:
- Walks every set and way of a set-associative cache on a flush request and writes back each valid dirty line over a req/ack handshake.
- Drives FlushAdr into the cache's set-address mux, which feeds the tag/dirty arrays and the pseudo-LRU block.
- Clears each dirty bit once its line has been written back.
- Pulses FlushDone when the whole cache is clean.

Parameters:
- NUMWAYS, 4: associativity; power of 2, >=2.
- NUMLINES, 128: sets per way; power of 2.
- SETLEN, 7: set index width; must equal $clog2(NUMLINES).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- FlushStart  in  1  one-cycle request to begin a flush; honoured only in IDLE.
- ValidWay  in  NUMWAYS  valid bits of set FlushAdr; arrives 1 cycle after FlushAdr is presented (registered array read).
- DirtyWay  in  NUMWAYS  dirty bits of set FlushAdr; same timing as ValidWay.
- WritebackAck  in  1  bus has accepted the writeback of FlushAdr/FlushWay.
- FlushAdr  out  SETLEN  set index being flushed.
- FlushWay  out  NUMWAYS  one-hot way being examined.
- SelFlush  out  1  select FlushAdr in the cache address mux; high in every non-IDLE state.
- WritebackReq  out  1  request a writeback of line (FlushAdr, FlushWay).
- ClearDirty  out  1  one-cycle strobe: clear the dirty bit of (FlushAdr, FlushWay).
- FlushDone  out  1  one-cycle completion pulse.

Behaviour:
- State: FSM {IDLE, READ, CHECK, WB, CLEAR, DONE}; SetCnt (SETLEN bits); WayCnt ($clog2(NUMWAYS) bits). All reset asynchronously to IDLE / 0.
- Output mapping:
  - FlushAdr = SetCnt.
  - FlushWay = decode(WayCnt).
  - SelFlush = (state != IDLE).
  - WritebackReq = (state == WB).
  - ClearDirty = (state == CLEAR).
  - FlushDone = (state == DONE).
- Reset value of all outputs: 0. FlushWay is 0 only while reset is asserted; once reset deasserts in IDLE, FlushWay = decode(0) = 1. FlushWay is don't-care while SelFlush=0.
- IDLE: on FlushStart, go to READ with SetCnt=0, WayCnt=0.
- READ: one cycle for the array read; go to CHECK.
- CHECK: sample ValidWay[WayCnt] & DirtyWay[WayCnt].
  - If 1, go to WB.
  - If 0, advance (see below).
- WB: hold WritebackReq until WritebackAck is sampled high, then go to CLEAR. Ack may arrive in the first WB cycle; minimum WB length is 1 cycle. Ack outside WB is ignored.
- CLEAR: one-cycle ClearDirty, then advance.
- Advance rule, from CHECK or CLEAR:
  - WayCnt < NUMWAYS-1: WayCnt++, go to CHECK. The array data for this set is still held, and only other ways' bits are unaffected by ClearDirty.
  - WayCnt = NUMWAYS-1 and SetCnt < NUMLINES-1: WayCnt=0, SetCnt++, go to READ.
  - WayCnt = NUMWAYS-1 and SetCnt = NUMLINES-1: go to DONE.
- DONE: FlushDone=1 for one cycle, then IDLE. SetCnt and WayCnt return to 0.
- Latency:
  - Clean cache: FlushStart at cycle 0, FlushDone at cycle NUMLINES*(1+NUMWAYS)+1.
  - Each dirty line adds 1 CLEAR cycle plus its WB cycles.
- Boundary and illegal conditions:
  - FlushStart outside IDLE is ignored, including during DONE; no restart or queueing.
  - Set and way counters never wrap silently; the terminal set/way always goes to DONE.
  - A line that is dirty but not valid is skipped and not written back.
  - Reset mid-flush: asynchronously back to IDLE with all outputs 0. No partial ClearDirty is emitted, and no completion pulse.
  - WritebackAck held high across consecutive WB entries is legal; each entry consumes one ack cycle.

Test Plan:
- Clean flush: NUMWAYS=4, NUMLINES=4, all DirtyWay=0. FlushStart at cycle 0 -> FlushDone pulse exactly at cycle 21; WritebackReq never high; SelFlush high cycles 1-21.
- Single dirty line: set 2, way 3 valid+dirty; ack 3 cycles after WritebackReq rises -> one WritebackReq with FlushAdr=2, FlushWay=4'b1000 held 4 cycles; one ClearDirty; FlushDone at cycle 26.
- All dirty: every line valid+dirty (NUMWAYS=4, NUMLINES=4); WritebackAck tied high -> 16 writebacks in set-major, way-minor order (0/0001 ... 3/1000); 16 ClearDirty strobes; FlushDone at cycle 53.
- Dirty-not-valid: DirtyWay=4'b1111, ValidWay=4'b0000 in every set -> no WritebackReq; same latency as the clean flush.
- Reset mid-WB: assert reset while WritebackReq=1 -> all outputs 0 immediately (asynchronous). A subsequent FlushStart restarts from FlushAdr=0, FlushWay=4'b0001.
- FlushStart spam: pulse FlushStart every cycle during a flush -> exactly one FlushDone; the walk is unaffected. A new flush starts only on a FlushStart seen in IDLE.
